// File: rtl/usb_utmi_pkg.sv
// Shared UTMI encodings, link-state enum and timing helper for the FS device link controller.
package usb_utmi_pkg;

  // UTMI line_state encodings, {DM,DP}
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  // UTMI op_mode encodings
  localparam logic [1:0] OPM_NORMAL = 2'b00;
  localparam logic [1:0] OPM_NODRV  = 2'b01;
  localparam logic [1:0] OPM_RAW    = 2'b10;

  typedef enum logic [2:0] {
    DETACHED,
    CONNECT,
    ACTIVE,
    BUS_RESET,
    SUSPEND,
    RWAKE,
    HOST_RESUME
  } usb_line_state_t;

  // Converts a clock frequency and a num/den ratio into a cycle count using
  // 64-bit intermediates so large clocks do not overflow the product.
  function automatic int scale_ticks(input longint hz, input longint num, input longint den);
    scale_ticks = int'((hz * num) / den);
  endfunction

endpackage

// File: rtl/usb_line_timer.sv
// Saturating up-counter with synchronous clear, shared by every timed link state.
module usb_line_timer #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Count up every cycle, restart on clear, and hold once all ones is reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/usb_line_ctrl.sv
// FS device link-state controller: sequences attach, bus reset, suspend,
// host resume and remote wakeup, driving the UTM and the DP pull-up.
module usb_line_ctrl
  import usb_utmi_pkg::*;
#(
  parameter int CLK_FREQ_HZ      = 48_000_000,
  parameter int CONNECT_DELAY_US = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] line_state,
  input  logic       rx_active,
  input  logic       tx_valid,
  input  logic       remote_wakeup_req,
  output logic       pu,
  output logic       suspend_m,
  output logic [1:0] op_mode,
  output logic       drive_k,
  output logic       usb_reset,
  output logic       suspended,
  output logic       resumed
);

  localparam int T_RST  = scale_ticks(longint'(CLK_FREQ_HZ), 64'sd1, 64'sd400_000);
  localparam int T_SUSP = scale_ticks(longint'(CLK_FREQ_HZ), 64'sd3, 64'sd1_000);
  localparam int T_RWK  = scale_ticks(longint'(CLK_FREQ_HZ), 64'sd5, 64'sd1_000);
  localparam int T_K    = scale_ticks(longint'(CLK_FREQ_HZ), 64'sd2, 64'sd1_000);
  localparam int T_CON  = scale_ticks(longint'(CLK_FREQ_HZ), longint'(CONNECT_DELAY_US), 64'sd1_000_000);
  localparam int TW     = $clog2(T_RWK + 1);

  // After a line edge the timer reads 0 one cycle into the new level, so a
  // level has been held for (timer + 2) cycles when it is evaluated.
  localparam logic [TW-1:0] RST_HELD  = TW'(T_RST - 2);
  localparam logic [TW-1:0] SUSP_HELD = TW'(T_SUSP - 2);
  localparam logic [TW-1:0] RWK_DONE  = TW'(T_RWK);
  localparam logic [TW-1:0] K_DONE    = TW'(T_K - 1);
  localparam logic [TW-1:0] CON_DONE  = TW'(T_CON - 1);

  usb_line_state_t state;
  usb_line_state_t state_next;

  logic [1:0]    ls_prev;
  logic          line_changed;
  logic          se0_held;
  logic          idle_held;
  logic          wake_pend;
  logic          timer_clr;
  logic [TW-1:0] timer_cnt;

  logic          pu_next;
  logic          suspend_m_next;
  logic [1:0]    op_mode_next;
  logic          drive_k_next;
  logic          usb_reset_next;
  logic          suspended_next;
  logic          resumed_next;

  usb_line_timer #(
    .W (TW)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .cnt (timer_cnt)
  );

  assign line_changed = (line_state != ls_prev);

  // SE1 is neither SE0 nor J, so it breaks both the reset and the idle qualifiers.
  assign se0_held  = (line_state == LS_SE0) && !line_changed && (timer_cnt >= RST_HELD);
  assign idle_held = (line_state == LS_J) && !line_changed && !rx_active && !tx_valid &&
                     (timer_cnt >= SUSP_HELD);

  // Next-state selection, timer clear and the output values for the state being entered.
  always_comb begin
    state_next     = state;
    resumed_next   = 1'b0;
    pu_next        = 1'b1;
    suspend_m_next = 1'b1;
    op_mode_next   = OPM_NODRV;
    drive_k_next   = 1'b0;
    usb_reset_next = 1'b0;
    suspended_next = 1'b0;
    timer_clr      = 1'b0;

    case (state)
      DETACHED: begin
        if (enable) state_next = CONNECT;
      end
      CONNECT: begin
        if (timer_cnt == CON_DONE) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (se0_held) begin
          state_next = BUS_RESET;
        end else if (idle_held) begin
          state_next = SUSPEND;
        end
      end
      BUS_RESET: begin
        if (line_state != LS_SE0) state_next = ACTIVE;
      end
      SUSPEND: begin
        if (line_state != LS_J) begin
          state_next = HOST_RESUME;
        end else if ((wake_pend || remote_wakeup_req) && (timer_cnt >= RWK_DONE)) begin
          state_next = RWAKE;
        end
      end
      RWAKE: begin
        if (timer_cnt >= K_DONE) state_next = HOST_RESUME;
      end
      HOST_RESUME: begin
        if (line_state == LS_J) begin
          state_next   = ACTIVE;
          resumed_next = 1'b1;
        end else if (se0_held) begin
          state_next = BUS_RESET;
        end
      end
      default: state_next = DETACHED;
    endcase

    if (!enable) begin
      state_next   = DETACHED;
      resumed_next = 1'b0;
    end

    // While we drive K ourselves the echoed line edges must not stretch the K pulse.
    timer_clr = (state_next != state) ||
                (line_changed && (state != RWAKE)) ||
                ((state == ACTIVE) && (rx_active || tx_valid));

    case (state_next)
      DETACHED: begin
        pu_next = 1'b0;
      end
      CONNECT: begin
        pu_next = 1'b0;
      end
      ACTIVE: begin
        op_mode_next = OPM_NORMAL;
      end
      BUS_RESET: begin
        op_mode_next   = OPM_NORMAL;
        usb_reset_next = 1'b1;
      end
      SUSPEND: begin
        suspend_m_next = 1'b0;
        suspended_next = 1'b1;
      end
      RWAKE: begin
        op_mode_next = OPM_RAW;
        drive_k_next = 1'b1;
      end
      HOST_RESUME: begin
        op_mode_next = OPM_NODRV;
      end
      default: begin
        pu_next = 1'b0;
      end
    endcase
  end

  // Link-state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DETACHED;
    end else begin
      state <= state_next;
    end
  end

  // Registered outputs follow the state being entered so they change with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pu        <= 1'b0;
      suspend_m <= 1'b1;
      op_mode   <= OPM_NODRV;
      drive_k   <= 1'b0;
      usb_reset <= 1'b0;
      suspended <= 1'b0;
      resumed   <= 1'b0;
    end else begin
      pu        <= pu_next;
      suspend_m <= suspend_m_next;
      op_mode   <= op_mode_next;
      drive_k   <= drive_k_next;
      usb_reset <= usb_reset_next;
      suspended <= suspended_next;
      resumed   <= resumed_next;
    end
  end

  // Previous line level for edge detection, and the wakeup latch that only lives inside SUSPEND.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ls_prev   <= LS_SE0;
      wake_pend <= 1'b0;
    end else begin
      ls_prev <= line_state;
      if ((state == SUSPEND) && (state_next == SUSPEND)) begin
        wake_pend <= wake_pend || remote_wakeup_req;
      end else begin
        wake_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usb_line_ctrl.sv
// Directed bench for usb_line_ctrl with a scaled clock so every timed phase stays short.
module tb_usb_line_ctrl;

  localparam int CLK_HZ  = 2_000_000;
  localparam int CON_US  = 10;
  localparam int T_RST   = CLK_HZ / 400_000;
  localparam int T_SUSP  = 3 * CLK_HZ / 1000;
  localparam int T_RWK   = 5 * CLK_HZ / 1000;
  localparam int T_K     = 2 * CLK_HZ / 1000;
  localparam int T_CON   = CON_US * (CLK_HZ / 1_000_000);
  localparam int P_TX    = 2 * T_SUSP / 3;

  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] LJ  = 2'b01;
  localparam logic [1:0] LK  = 2'b10;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [1:0] line_state;
  logic       rx_active;
  logic       tx_valid;
  logic       remote_wakeup_req;
  logic       pu;
  logic       suspend_m;
  logic [1:0] op_mode;
  logic       drive_k;
  logic       usb_reset;
  logic       suspended;
  logic       resumed;

  int nAssert = 0;
  int nFail   = 0;

  usb_line_ctrl #(
    .CLK_FREQ_HZ      (CLK_HZ),
    .CONNECT_DELAY_US (CON_US)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .line_state        (line_state),
    .rx_active         (rx_active),
    .tx_valid          (tx_valid),
    .remote_wakeup_req (remote_wakeup_req),
    .pu                (pu),
    .suspend_m         (suspend_m),
    .op_mode           (op_mode),
    .drive_k           (drive_k),
    .usb_reset         (usb_reset),
    .suspended         (suspended),
    .resumed           (resumed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] ls, input logic rx, input logic tx, input logic wk);
    line_state        = ls;
    rx_active         = rx;
    tx_valid          = tx;
    remote_wakeup_req = wk;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] expw(input logic p, input logic sm, input logic [1:0] om,
                                      input logic dk, input logic ur, input logic su, input logic rs);
    expw = {p, sm, om, dk, ur, su, rs};
  endfunction

  task automatic checkAll(input string tag, input logic [7:0] exp);
    checkOutput(tag, {pu, suspend_m, op_mode, drive_k, usb_reset, suspended, resumed}, exp);
  endtask

  initial begin
    rst    = 1'b0;
    enable = 1'b0;
    applyStimulus(LJ, 1'b0, 1'b0, 1'b0);
    step(3);
    checkAll("reset_values", expw(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));

    $display("[TB] attach");
    rst    = 1'b1;
    enable = 1'b1;
    step(1);
    checkOutput("connect_pu_first", 8'(pu), 8'd0);
    step(T_CON - 1);
    checkAll("connect_pu_last", expw(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1);
    checkAll("active_entry", expw(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));

    $display("[TB] bus reset");
    applyStimulus(SE0, 1'b0, 1'b0, 1'b0);
    step(T_RST - 1);
    applyStimulus(LJ, 1'b0, 1'b0, 1'b0);
    checkOutput("short_se0_a", 8'(usb_reset), 8'd0);
    step(1);
    checkOutput("short_se0_b", 8'(usb_reset), 8'd0);
    step(3);
    checkOutput("short_se0_c", 8'(usb_reset), 8'd0);
    applyStimulus(SE0, 1'b0, 1'b0, 1'b0);
    step(T_RST - 1);
    checkOutput("long_se0_before", 8'(usb_reset), 8'd0);
    step(1);
    checkAll("bus_reset_rise", expw(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
    step(199 - T_RST);
    checkOutput("bus_reset_hold", 8'(usb_reset), 8'd1);
    step(1);
    applyStimulus(LJ, 1'b0, 1'b0, 1'b0);
    checkOutput("bus_reset_last", 8'(usb_reset), 8'd1);
    step(1);
    checkAll("bus_reset_fall", expw(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));

    $display("[TB] suspend with tx restart");
    step(P_TX - 1);
    applyStimulus(LJ, 1'b0, 1'b1, 1'b0);
    step(1);
    applyStimulus(LJ, 1'b0, 1'b0, 1'b0);
    step(T_SUSP - P_TX - 1);
    checkOutput("idle_restart", 8'(suspended), 8'd0);
    step(P_TX - 1);
    checkAll("pre_suspend", expw(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1);
    checkAll("suspend_entry", expw(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0));

    $display("[TB] host resume");
    step(10);
    applyStimulus(LK, 1'b0, 1'b0, 1'b0);
    step(1);
    checkAll("host_resume_entry", expw(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
    step(998);
    checkAll("host_resume_hold", expw(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1);
    applyStimulus(SE0, 1'b0, 1'b0, 1'b0);
    step(2);
    applyStimulus(LJ, 1'b0, 1'b0, 1'b0);
    checkAll("resume_se0", expw(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1);
    checkAll("resumed_pulse", expw(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    step(1);
    checkOutput("resumed_once", 8'(resumed), 8'd0);

    $display("[TB] remote wakeup");
    step(T_SUSP - 3);
    checkOutput("idle_not_yet", 8'(suspended), 8'd0);
    step(1);
    checkOutput("suspend_again", 8'(suspended), 8'd1);
    step(1000);
    applyStimulus(LJ, 1'b0, 1'b0, 1'b1);
    step(1);
    applyStimulus(LJ, 1'b0, 1'b0, 1'b0);
    checkAll("wake_latched", expw(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0));
    step(T_RWK - 1001);
    checkAll("wake_not_yet", expw(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0));
    step(1);
    checkAll("rwake_entry", expw(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0));
    step(T_K - 1);
    checkAll("rwake_last", expw(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1);
    checkAll("rwake_done", expw(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1);
    checkAll("rwake_resumed", expw(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));

    $display("[TB] host activity beats wakeup");
    step(T_SUSP + 5);
    checkOutput("suspend_third", 8'(suspended), 8'd1);
    applyStimulus(LK, 1'b0, 1'b0, 1'b1);
    step(1);
    applyStimulus(LK, 1'b0, 1'b0, 1'b0);
    checkAll("host_wins", expw(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
    step(3);
    checkOutput("host_wins_no_k", 8'(drive_k), 8'd0);
    applyStimulus(LJ, 1'b0, 1'b0, 1'b0);
    step(1);
    checkOutput("host_wins_resumed", 8'(resumed), 8'd1);

    $display("[TB] detach and async reset");
    step(T_SUSP + 5);
    checkOutput("suspend_fourth", 8'(suspended), 8'd1);
    applyStimulus(LJ, 1'b0, 1'b0, 1'b1);
    step(1);
    applyStimulus(LJ, 1'b0, 1'b0, 1'b0);
    step(T_RWK + 5);
    checkAll("rwake_again", expw(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0));
    enable = 1'b0;
    step(1);
    checkAll("disable_rwake", expw(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
    enable = 1'b1;
    step(T_CON + 2);
    checkOutput("reconnect", 8'(pu), 8'd1);
    applyStimulus(SE0, 1'b0, 1'b0, 1'b0);
    step(T_RST + 3);
    checkOutput("reset_before_rst", 8'(usb_reset), 8'd1);
    rst = 1'b0;
    #1;
    checkAll("async_reset", expw(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
    step(2);
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
